clic_arbiter: RTL and testbench

CLIC_ARBITER -- requirements
Module: clic_arbiter

---
 rtl/clic_arbiter.sv | 101 ++++++++++
 tb/tb_clic_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/clic_arbiter.sv
// Sequential CLIC arbiter: scans one source per cycle and presents the best one above threshold.
// Request rises N cycles after sweep start; no backpressure, it holds until ack or withdraw.
module clic_arbiter #(
  parameter int clic_sources = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [(2**clic_sources)-1:0]   clic_int_ip,
  input  logic [(2**clic_sources)-1:0]   clic_int_ie,
  input  logic [8*(2**clic_sources)-1:0] clic_int_ctl,
  input  logic [7:0]                     clic_mth,
  input  logic                           clic_ack,
  output logic                           clic_meip,
  output logic [clic_sources-1:0]        clic_id,
  output logic [7:0]                     clic_level,
  output logic                           clic_clear,
  output logic [clic_sources-1:0]        clic_clear_id
);

  localparam logic [clic_sources-1:0] IDX_MAX = '1;
  localparam logic [clic_sources-1:0] IDX_ONE = 1;

  typedef enum logic {SCAN, PRESENT} state_t;

  state_t                  state;
  logic [clic_sources-1:0] idx;
  logic                    cand_vld;
  logic [clic_sources-1:0] cand_id;
  logic [7:0]              cand_lvl;

  logic                    scan_elig;
  logic [7:0]              scan_lvl;
  logic                    take;
  logic                    nxt_vld;
  logic [clic_sources-1:0] nxt_id;
  logic [7:0]              nxt_lvl;
  logic [7:0]              pres_lvl;
  logic                    withdraw;

  always_comb begin
    scan_lvl  = clic_int_ctl[{idx, 3'b000} +: 8];
    scan_elig = clic_int_ip[idx] & clic_int_ie[idx];
    // Ascending scan with strict compare keeps the lower id on ties.
    take      = scan_elig && (!cand_vld || (scan_lvl > cand_lvl));
    nxt_vld   = cand_vld | take;
    nxt_id    = take ? idx : cand_id;
    nxt_lvl   = take ? scan_lvl : cand_lvl;
    pres_lvl  = clic_int_ctl[{clic_id, 3'b000} +: 8];
    withdraw  = !clic_int_ip[clic_id] || !clic_int_ie[clic_id] || (pres_lvl <= clic_mth);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SCAN;
      idx           <= '0;
      cand_vld      <= 1'b0;
      cand_id       <= '0;
      cand_lvl      <= 8'd0;
      clic_meip     <= 1'b0;
      clic_id       <= '0;
      clic_level    <= 8'd0;
      clic_clear    <= 1'b0;
      clic_clear_id <= '0;
    end else begin
      clic_clear <= 1'b0;
      if (state == SCAN) begin
        if (idx == IDX_MAX) begin
          if (nxt_vld && (nxt_lvl > clic_mth)) begin
            state      <= PRESENT;
            clic_meip  <= 1'b1;
            clic_id    <= nxt_id;
            clic_level <= nxt_lvl;
          end
          idx      <= '0;
          cand_vld <= 1'b0;
        end else begin
          idx      <= idx + IDX_ONE;
          cand_vld <= nxt_vld;
          cand_id  <= nxt_id;
          cand_lvl <= nxt_lvl;
        end
      end else begin
        // Withdraw wins over a coincident ack; neither path preempts for a new source.
        if (withdraw) begin
          state     <= SCAN;
          clic_meip <= 1'b0;
          idx       <= '0;
          cand_vld  <= 1'b0;
        end else if (clic_ack) begin
          state         <= SCAN;
          clic_meip     <= 1'b0;
          clic_clear    <= 1'b1;
          clic_clear_id <= clic_id;
          idx           <= '0;
          cand_vld      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clic_arbiter.sv
// Directed bench for clic_arbiter: a 4-source instance plus a 128-source instance.
module tb_clic_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ip, ie;
  logic [31:0] ctl;
  logic [7:0]  mth;
  logic        ack;
  logic        meip, clear;
  logic [1:0]  id, clear_id;
  logic [7:0]  level;

  logic [127:0]  ip_w, ie_w;
  logic [1023:0] ctl_w;
  logic [7:0]    mth_w;
  logic          ack_w;
  logic          meip_w, clear_w;
  logic [6:0]    id_w, clear_id_w;
  logic [7:0]    level_w;

  int n_chk = 0;
  int n_fail = 0;
  int cnt;

  always #5 clk = ~clk;

  clic_arbiter #(.clic_sources(2)) dut (
    .clk(clk), .rst(rst), .clic_int_ip(ip), .clic_int_ie(ie), .clic_int_ctl(ctl),
    .clic_mth(mth), .clic_ack(ack), .clic_meip(meip), .clic_id(id), .clic_level(level),
    .clic_clear(clear), .clic_clear_id(clear_id)
  );

  clic_arbiter #(.clic_sources(7)) dut_w (
    .clk(clk), .rst(rst), .clic_int_ip(ip_w), .clic_int_ie(ie_w), .clic_int_ctl(ctl_w),
    .clic_mth(mth_w), .clic_ack(ack_w), .clic_meip(meip_w), .clic_id(id_w), .clic_level(level_w),
    .clic_clear(clear_w), .clic_clear_id(clear_id_w)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; mth = 8'd0;
    ip = 4'b0100; ie = 4'b0100; ctl = '0; ctl[16 +: 8] = 8'd5;
    ip_w = '0; ie_w = '0; ctl_w = '0; mth_w = 8'd254; ack_w = 1'b0;
    ip_w[127] = 1'b1; ie_w[127] = 1'b1; ctl_w[1016 +: 8] = 8'd255;

    // Reset state
    step(2);
    chk("rst_meip", meip, 0);
    chk("rst_id", id, 0);
    chk("rst_level", level, 0);
    chk("rst_clear", clear, 0);
    chk("rst_clear_id", clear_id, 0);
    chk("rst_meip_w", meip_w, 0);

    // Single source: request on the 4th edge after release
    rst = 1'b0;
    step(3);
    chk("single_early", meip, 0);
    step(1);
    chk("single_meip", meip, 1);
    chk("single_id", id, 2);
    chk("single_level", level, 5);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("ack_clear", clear, 1);
    chk("ack_clear_id", clear_id, 2);
    chk("ack_meip", meip, 0);
    step(1);
    chk("clear_pulse_one", clear, 0);
    chk("id_retained", id, 2);
    chk("level_retained", level, 5);
    // Still pending: re-presented 4 edges after the ack edge
    step(2);
    chk("repres_early", meip, 0);
    step(1);
    chk("repres_meip", meip, 1);

    // Priority and tie: 1 and 3 at 7, 2 at 3
    ip = 4'b1110; ie = 4'b1110;
    ctl = '0; ctl[8 +: 8] = 8'd7; ctl[16 +: 8] = 8'd3; ctl[24 +: 8] = 8'd7;
    do_reset();
    step(4);
    chk("prio_meip", meip, 1);
    chk("prio_id", id, 1);
    chk("prio_level", level, 7);
    ip = 4'b0000;
    step(1);
    chk("prio_withdraw_meip", meip, 0);
    chk("prio_withdraw_clear", clear, 0);

    // Threshold: level 4 never beats mth 4; beats mth 3
    ip = 4'b0001; ie = 4'b0001; ctl = '0; ctl[0 +: 8] = 8'd4; mth = 8'd4;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (meip !== 1'b0) cnt++;
    end
    chk("thr_hold_low", cnt, 0);
    mth = 8'd3;
    cnt = 0;
    while (meip !== 1'b1 && cnt < 9) begin
      step(1);
      cnt++;
    end
    chk("thr_meip", meip, 1);
    chk("thr_within_8", (cnt <= 8) ? 1 : 0, 1);
    chk("thr_id", id, 0);
    chk("thr_level", level, 4);

    // No preemption, then withdraw beats a coincident ack
    ip = 4'b0100; ie = 4'b0100; ctl = '0; ctl[16 +: 8] = 8'd5; mth = 8'd0;
    do_reset();
    step(4);
    chk("wd_meip", meip, 1);
    chk("wd_id", id, 2);
    ip = 4'b1100; ie = 4'b1100; ctl[24 +: 8] = 8'd9;
    step(2);
    chk("nopreempt_meip", meip, 1);
    chk("nopreempt_id", id, 2);
    chk("nopreempt_level", level, 5);
    ie = 4'b1000; ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("wd_meip_drop", meip, 0);
    chk("wd_no_clear", clear, 0);
    step(3);
    chk("wd_rescan_early", meip, 0);
    step(1);
    chk("wd_rescan_meip", meip, 1);
    chk("wd_rescan_id", id, 3);
    chk("wd_rescan_level", level, 9);

    // Reset while presenting
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_meip", meip, 0);
    chk("midrst_id", id, 0);
    chk("midrst_level", level, 0);
    chk("midrst_clear", clear, 0);
    step(3);
    chk("midrst_early", meip, 0);
    step(1);
    chk("midrst_meip_again", meip, 1);
    chk("midrst_id_again", id, 3);

    // Full width: source 127 at 255 over mth 254
    do_reset();
    step(127);
    chk("wide_early", meip_w, 0);
    step(1);
    chk("wide_meip", meip_w, 1);
    chk("wide_id", id_w, 127);
    chk("wide_level", level_w, 255);
    chk("wide_clear", clear_w, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
